// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment snooper and the display driver.
package seg_pkg;

    localparam int unsigned NUM_DIGITS = 6;
    localparam int unsigned NIBBLE_W   = 4;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned DATA_W     = NUM_DIGITS * NIBBLE_W;

    // Active-high segment patterns, bit order g..a
    localparam logic [SEG_W-1:0] SEG_0 = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1 = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2 = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3 = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4 = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5 = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6 = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7 = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9 = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_A = 7'h77;
    localparam logic [SEG_W-1:0] SEG_B = 7'h7C;
    localparam logic [SEG_W-1:0] SEG_C = 7'h39;
    localparam logic [SEG_W-1:0] SEG_D = 7'h5E;
    localparam logic [SEG_W-1:0] SEG_E = 7'h79;
    localparam logic [SEG_W-1:0] SEG_F = 7'h71;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } seg_state_e;

    // True when exactly one digit select is lit
    function automatic logic is_one_hot(input logic [NUM_DIGITS-1:0] v);
        return (v != '0) && ((v & (v - NUM_DIGITS'(1))) == '0);
    endfunction

    // Position of the lit select bit (meaningful only for one-hot input)
    function automatic logic [2:0] one_hot_idx(input logic [NUM_DIGITS-1:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Seven-segment pattern to hex nibble lookup; unknown patterns flag invalid.
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [SEG_W-1:0]    pattern,
    output logic [NIBBLE_W-1:0] nibble_c,
    output logic                invalid_c
);

    // Table lookup; anything off-table decodes to zero with the flag raised
    always_comb begin
        nibble_c  = '0;
        invalid_c = 1'b0;
        case (pattern)
            SEG_0:   nibble_c = 4'h0;
            SEG_1:   nibble_c = 4'h1;
            SEG_2:   nibble_c = 4'h2;
            SEG_3:   nibble_c = 4'h3;
            SEG_4:   nibble_c = 4'h4;
            SEG_5:   nibble_c = 4'h5;
            SEG_6:   nibble_c = 4'h6;
            SEG_7:   nibble_c = 4'h7;
            SEG_8:   nibble_c = 4'h8;
            SEG_9:   nibble_c = 4'h9;
            SEG_A:   nibble_c = 4'hA;
            SEG_B:   nibble_c = 4'hB;
            SEG_C:   nibble_c = 4'hC;
            SEG_D:   nibble_c = 4'hD;
            SEG_E:   nibble_c = 4'hE;
            SEG_F:   nibble_c = 4'hF;
            default: invalid_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_decode.sv
// Snoops a multiplexed six-digit seven-segment display and rebuilds the shown value.
module seg_decode
    import seg_pkg::*;
#(
    parameter int unsigned STABLE_CYC  = 16,
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_DIGITS-1:0] seg_sel,
    input  logic [7:0]            seg_led,
    output logic [DATA_W-1:0]     data,
    output logic                  data_valid,
    output logic [NUM_DIGITS-1:0] digit_err,
    output logic                  active
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYC + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);

    logic [NUM_DIGITS-1:0] sel_s1, sel_s2, sel_p;
    logic [7:0]            led_s1, led_s2, led_p;

    seg_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [NUM_DIGITS-1:0] cap_sel_q;
    logic [TO_W-1:0]       to_cnt_q;

    logic [NUM_DIGITS-1:0]               mask_q, mask_d;
    logic [NUM_DIGITS-1:0]               err_q, err_d;
    logic [NUM_DIGITS-1:0][NIBBLE_W-1:0] shd_q, shd_d;

    logic                  same_c, one_hot_c;
    logic                  capture_c, cnt_load_c, cnt_inc_c;
    logic                  frame_done_c, to_sat_c;
    logic [2:0]            cap_idx_c;
    logic [NIBBLE_W-1:0]   nibble_c;
    logic                  invalid_c;

    seg_pattern_decode u_pat (
        .pattern   (led_s2[SEG_W-1:0]),
        .nibble_c  (nibble_c),
        .invalid_c (invalid_c)
    );

    assign same_c       = ({sel_s2, led_s2} == {sel_p, led_p});
    assign one_hot_c    = is_one_hot(sel_s2);
    assign cap_idx_c    = one_hot_idx(sel_s2);
    assign frame_done_c = (mask_q == {NUM_DIGITS{1'b1}});
    assign to_sat_c     = (to_cnt_q == TO_W'(TIMEOUT_CYC));

    // Two-flop synchronizer plus a one-cycle history for the stability compare
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_s1 <= '0;
            sel_s2 <= '0;
            sel_p  <= '0;
            led_s1 <= '0;
            led_s2 <= '0;
            led_p  <= '0;
        end else begin
            sel_s1 <= seg_sel;
            sel_s2 <= sel_s1;
            sel_p  <= sel_s2;
            led_s1 <= seg_led;
            led_s2 <= led_s1;
            led_p  <= led_s2;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (one_hot_c) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (same_c) begin
                    if (cnt_q == CNT_W'(STABLE_CYC - 1)) state_d = ST_HOLD;
                end else if (!one_hot_c) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (sel_s2 != cap_sel_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM control outputs: counter load/increment and digit capture strobe
    always_comb begin
        cnt_load_c = 1'b0;
        cnt_inc_c  = 1'b0;
        capture_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_load_c = one_hot_c;
            end
            ST_SETTLE: begin
                if (same_c) begin
                    if (cnt_q == CNT_W'(STABLE_CYC - 1)) capture_c = 1'b1;
                    else                                 cnt_inc_c = 1'b1;
                end else if (one_hot_c) begin
                    cnt_load_c = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Stability counter and the select value that was captured
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            cap_sel_q <= '0;
        end else begin
            if (cnt_load_c)     cnt_q <= CNT_W'(1);
            else if (cnt_inc_c) cnt_q <= cnt_q + CNT_W'(1);
            if (capture_c)      cap_sel_q <= sel_s2;
        end
    end

    // Shadow frame update: clear on completion or timeout, then apply any new capture
    always_comb begin
        mask_d = mask_q;
        err_d  = err_q;
        shd_d  = shd_q;
        if (frame_done_c) begin
            mask_d = '0;
            err_d  = '0;
            shd_d  = '0;
        end else if (to_sat_c) begin
            mask_d = '0;
            err_d  = '0;
        end
        if (capture_c) begin
            mask_d[cap_idx_c] = 1'b1;
            err_d[cap_idx_c]  = invalid_c;
            shd_d[cap_idx_c]  = nibble_c;
        end
    end

    // Shadow registers, link timeout and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mask_q     <= '0;
            err_q      <= '0;
            shd_q      <= '0;
            to_cnt_q   <= '0;
            data       <= '0;
            data_valid <= 1'b0;
            digit_err  <= '0;
            active     <= 1'b0;
        end else begin
            mask_q     <= mask_d;
            err_q      <= err_d;
            shd_q      <= shd_d;
            data_valid <= frame_done_c;
            if (capture_c)      to_cnt_q <= '0;
            else if (!to_sat_c) to_cnt_q <= to_cnt_q + TO_W'(1);
            if (frame_done_c) begin
                data      <= shd_q;
                digit_err <= err_q;
                active    <= 1'b1;
            end else if (to_sat_c) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_decode.sv
// Scoreboard bench for seg_decode: expected frames queued at drive time, checked on data_valid.
module tb_seg_decode;

    localparam int unsigned SLOT  = 200;
    localparam int unsigned BLANK = 20;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  seg_sel;
    logic [7:0]  seg_led;
    logic [23:0] data;
    logic        data_valid;
    logic [5:0]  digit_err;
    logic        active;

    int total = 0;
    int bad   = 0;

    logic [6:0] pat [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    typedef struct packed {
        logic [23:0] d;
        logic [5:0]  e;
    } exp_t;

    exp_t sbq[$];

    seg_decode #(.STABLE_CYC(16), .TIMEOUT_CYC(2000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_sel    (seg_sel),
        .seg_led    (seg_led),
        .data       (data),
        .data_valid (data_valid),
        .digit_err  (digit_err),
        .active     (active)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Every data_valid pulse must match the oldest queued frame
    always @(negedge clk) begin
        if (data_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("data", 32'(data), 32'(e.d));
                check("digit_err", 32'(digit_err), 32'(e.e));
                check("active_on_valid", 32'(active), 32'd1);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drive_digit(input int i, input logic [3:0] nib, input bit bad_pat);
        seg_sel = 6'(1 << i);
        seg_led = {1'($urandom_range(0, 1)), bad_pat ? 7'h00 : pat[nib]};
        idle(SLOT);
        seg_sel = '0;
        seg_led = '0;
        idle(BLANK);
    endtask

    task automatic push_frame(input logic [23:0] val, input logic [5:0] bmask);
        exp_t e;
        e.d = val;
        for (int i = 0; i < 6; i++) if (bmask[i]) e.d[4*i +: 4] = 4'h0;
        e.e = bmask;
        sbq.push_back(e);
    endtask

    task automatic drive_frame(input logic [23:0] val, input logic [5:0] bmask);
        push_frame(val, bmask);
        for (int i = 0; i < 6; i++) drive_digit(i, val[4*i +: 4], bmask[i]);
    endtask

    initial begin
        rst_n   = 1'b0;
        seg_sel = '0;
        seg_led = '0;
        idle(3);
        @(negedge clk);
        check("rst_data", 32'(data), 32'd0);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_err", 32'(digit_err), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        rst_n = 1'b1;
        idle(5);

        // Plain scan
        drive_frame(24'h12AB9F, 6'b000000);
        check("frame1_pending", 32'(sbq.size()), 32'd0);
        check("frame1_active", 32'(active), 32'd1);

        // Short glitch on digit 2 must not be captured
        seg_sel = 6'b000100;
        seg_led = {1'b0, 7'h7F};
        idle(10);
        seg_sel = '0;
        seg_led = '0;
        idle(BLANK);
        drive_frame(24'h000000, 6'b000000);
        check("glitch_pending", 32'(sbq.size()), 32'd0);
        check("glitch_data", 32'(data), 32'h000000);

        // Undecodable pattern on digit 2
        drive_frame(24'h345678, 6'b000100);
        check("err_pending", 32'(sbq.size()), 32'd0);

        // Two selects lit at once mid-frame: ignored
        push_frame(24'h5E7D01, 6'b000000);
        for (int i = 0; i < 3; i++) drive_digit(i, 4'(24'h5E7D01 >> (4*i)), 1'b0);
        seg_sel = 6'b000011;
        seg_led = {1'b0, 7'h7F};
        idle(500);
        seg_sel = '0;
        seg_led = '0;
        idle(BLANK);
        for (int i = 3; i < 6; i++) drive_digit(i, 4'(24'h5E7D01 >> (4*i)), 1'b0);
        check("multisel_pending", 32'(sbq.size()), 32'd0);

        // Reset after three captures discards the partial frame
        for (int i = 0; i < 3; i++) drive_digit(i, 4'h7, 1'b0);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_data", 32'(data), 32'd0);
        check("midrst_active", 32'(active), 32'd0);
        idle(5);
        drive_frame(24'h9C0DE4, 6'b000000);
        check("postrst_pending", 32'(sbq.size()), 32'd0);

        // Partial frame then silence: link times out, data held
        for (int i = 0; i < 3; i++) drive_digit(i, 4'h1, 1'b0);
        idle(2100);
        check("timeout_active", 32'(active), 32'd0);
        check("timeout_data", 32'(data), 32'h9C0DE4);
        drive_frame(24'hFEDCBA, 6'b000000);
        check("recover_pending", 32'(sbq.size()), 32'd0);
        check("recover_active", 32'(active), 32'd1);
        check("recover_data", 32'(data), 32'hFEDCBA);

        idle(50);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
